// File: rtl/sa_matmul_engine.sv
// ---------------------------------------------------------------------------
// sa_matmul_engine
//
// Parametrised N x N output-stationary systolic matrix-multiply engine.
// A job computes C = A * B, where A is N x K and B is K x N. Each input beat
// carries one column of A and one row of B. The beats are skewed internally
// so that operand k of A row i and of B column j meet in PE(i,j). Each PE
// accumulates locally. After the last beat has crossed the array, the N*N
// results drain row-major over a back-pressured output stream.
//
// Handshake rule, for both streams: a transfer happens on a rising edge
// where valid && ready are both high. The producer holds its payload stable
// while valid is high and ready is low. in_ready and out_valid depend only on
// registered state, never combinationally on the partner's valid/ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset; deassertion is synchronised
//   start      job request, sampled only while idle
//   k_len      inner dimension K, latched when start is taken
//   in_valid   beat present on a_col / b_row
//   in_ready   engine accepts a beat (LOAD state)
//   a_col      slice i = A[i][k]
//   b_row      slice j = B[k][j]
//   out_valid  result beat present (DRAIN state)
//   out_ready  consumer accepts the result beat
//   out_data   C[idx/N][idx%N]
//   out_idx    row-major result index
//   out_last   high with the final index N*N-1
//   busy       engine not idle
//   done       one-cycle pulse after the final result transfer
//   dbg_state  current controller state (IDLE=0, LOAD=1, FLUSH=2, DRAIN=3)
// ---------------------------------------------------------------------------
module sa_matmul_engine #(
  parameter int N      = 4,
  parameter int DW     = 16,
  parameter int AW     = 32,
  parameter int KW     = 8,
  parameter int SIGNED = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [KW-1:0]             k_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*DW-1:0]           a_col,
  input  logic [N*DW-1:0]           b_row,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [AW-1:0]             out_data,
  output logic [$clog2(N*N)-1:0]    out_idx,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                dbg_state
);

  localparam int IW = $clog2(N*N);
  localparam int FW = $clog2(2*N);
  localparam int PW = 2*DW;
  localparam logic [IW-1:0] LAST_IDX  = IW'(N*N-1);
  localparam logic [FW-1:0] FLUSH_LEN = FW'(2*N-1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  // -------------------------------------------------------------------------
  // Reset synchroniser. Assertion is immediate; release takes one edge, so
  // the controller can act on start from the second edge after rst rises.
  // -------------------------------------------------------------------------
  logic rst_sync_q;
  logic rst_n_int;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 1'b0;
    else      rst_sync_q <= 1'b1;
  end

  assign rst_n_int = rst_sync_q;

  // -------------------------------------------------------------------------
  // Controller
  // -------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [KW-1:0]   k_cnt_q, k_cnt_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  logic            done_q, done_d;
  logic            accept;
  logic            last_xfer;
  logic            clr_acc;
  logic            acc_en;

  assign accept    = in_valid && in_ready_q;
  assign last_xfer = (state_q == S_DRAIN) && out_ready && (idx_q == LAST_IDX);

  // The final FLUSH cycle (counter at zero) comes after the last possible
  // accumulation into PE(N-1,N-1), so accumulation is frozen from there on.
  assign acc_en = (state_q == S_LOAD) ||
                  ((state_q == S_FLUSH) && (flush_cnt_q != '0));

  always_comb begin
    state_d     = state_q;
    k_cnt_d     = k_cnt_q;
    flush_cnt_d = flush_cnt_q;
    idx_d       = idx_q;
    clr_acc     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          clr_acc = 1'b1;
          idx_d   = '0;
          if (k_len != '0) begin
            state_d = S_LOAD;
            k_cnt_d = k_len;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          k_cnt_d = k_cnt_q - 1'b1;
          if (k_cnt_q == KW'(1)) begin
            state_d     = S_FLUSH;
            flush_cnt_d = FLUSH_LEN;
          end
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d = S_DRAIN;
          idx_d   = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered copies of the next state.
    in_ready_d  = (state_d == S_LOAD);
    busy_d      = (state_d != S_IDLE);
    out_valid_d = (state_d == S_DRAIN);
    done_d      = last_xfer;
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q     <= S_IDLE;
      k_cnt_q     <= '0;
      flush_cnt_q <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_cnt_q     <= k_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Input skew. Each lane entry is {valid, data}. Lane i has i+1 registers:
  // one capture stage plus i delay stages. A beat accepted on edge e therefore
  // reaches PE(i,j) in the cycle after edge e+i+j.
  // -------------------------------------------------------------------------
  logic [DW:0] a_skew_w [N];
  logic [DW:0] b_skew_w [N];

  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DW:0] a_sr_q [i+1];
    logic [DW:0] a_sr_d [i+1];
    logic [DW:0] b_sr_q [i+1];
    logic [DW:0] b_sr_d [i+1];

    always_comb begin
      a_sr_d[0] = {accept, a_col[i*DW +: DW]};
      b_sr_d[0] = {accept, b_row[i*DW +: DW]};
      for (int k = 1; k <= i; k++) begin
        a_sr_d[k] = a_sr_q[k-1];
        b_sr_d[k] = b_sr_q[k-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
        for (int k = 0; k <= i; k++) begin
          a_sr_q[k] <= '0;
          b_sr_q[k] <= '0;
        end
      end else begin
        a_sr_q <= a_sr_d;
        b_sr_q <= b_sr_d;
      end
    end

    assign a_skew_w[i] = a_sr_q[i];
    assign b_skew_w[i] = b_sr_q[i];
  end

  // -------------------------------------------------------------------------
  // PE array. a moves right and b moves down one PE per cycle, each with its
  // valid tag. Bubbles carry a cleared tag and are never accumulated.
  // -------------------------------------------------------------------------
  logic [DW:0]   a_fw_w [N][N];
  logic [DW:0]   b_fw_w [N][N];
  logic [AW-1:0] acc_w  [N*N];

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW:0]   a_in, b_in;
      logic [DW:0]   a_q, b_q;
      logic [PW-1:0] a_ext, b_ext, prod;
      logic [AW-1:0] prod_ext;
      logic [AW-1:0] acc_q, acc_d;

      if (j == 0) begin : g_a_edge
        assign a_in = a_skew_w[i];
      end else begin : g_a_fwd
        assign a_in = a_fw_w[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_in = b_skew_w[j];
      end else begin : g_b_fwd
        assign b_in = b_fw_w[i-1][j];
      end

      // Operands are widened to the full product width first, so the low
      // PW bits of the product are exact for either signedness.
      always_comb begin
        if (SIGNED != 0) begin
          a_ext    = PW'($signed(a_in[DW-1:0]));
          b_ext    = PW'($signed(b_in[DW-1:0]));
          prod     = a_ext * b_ext;
          prod_ext = AW'($signed(prod));
        end else begin
          a_ext    = PW'(a_in[DW-1:0]);
          b_ext    = PW'(b_in[DW-1:0]);
          prod     = a_ext * b_ext;
          prod_ext = AW'(prod);
        end
      end

      always_comb begin
        acc_d = acc_q;
        if (clr_acc) begin
          acc_d = '0;
        end else if (acc_en && a_in[DW] && b_in[DW]) begin
          acc_d = acc_q + prod_ext;
        end
      end

      always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else begin
          a_q   <= a_in;
          b_q   <= b_in;
          acc_q <= acc_d;
        end
      end

      assign a_fw_w[i][j]   = a_q;
      assign b_fw_w[i][j]   = b_q;
      assign acc_w[i*N + j] = acc_q;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign out_idx   = idx_q;
  assign out_data  = out_valid_q ? acc_w[idx_q] : '0;
  assign out_last  = out_valid_q && (idx_q == LAST_IDX);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sa_matmul_engine.sv
// ---------------------------------------------------------------------------
// Bench for sa_matmul_engine. One unsigned and one signed instance are driven
// in lockstep from the same stimulus. Expected results are either literal
// values, for directed jobs, or a plain matrix product of the beats a job
// supplies, for random jobs.
// ---------------------------------------------------------------------------
module tb_sa_matmul_engine;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int KW = 8;
  localparam int NN = N*N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic            start = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic            in_valid = 1'b0;
  logic [N*DW-1:0] a_col = '0;
  logic [N*DW-1:0] b_row = '0;
  logic            out_ready = 1'b1;
  int              rdy_mode = 0;

  logic            u_in_ready, u_out_valid, u_out_last, u_busy, u_done;
  logic [AW-1:0]   u_out_data;
  logic [3:0]      u_out_idx;
  logic [1:0]      u_dbg_state;
  logic            s_in_ready, s_out_valid, s_out_last, s_busy, s_done;
  logic [AW-1:0]   s_out_data;
  logic [3:0]      s_out_idx;
  logic [1:0]      s_dbg_state;

  sa_matmul_engine #(.N(N), .DW(DW), .AW(AW), .KW(KW), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(u_in_ready), .a_col(a_col), .b_row(b_row),
    .out_valid(u_out_valid), .out_ready(out_ready), .out_data(u_out_data),
    .out_idx(u_out_idx), .out_last(u_out_last), .busy(u_busy), .done(u_done),
    .dbg_state(u_dbg_state)
  );

  sa_matmul_engine #(.N(N), .DW(DW), .AW(AW), .KW(KW), .SIGNED(1)) s_dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(s_in_ready), .a_col(a_col), .b_row(b_row),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_idx(s_out_idx), .out_last(s_out_last), .busy(s_busy), .done(s_done),
    .dbg_state(s_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [AW-1:0] exp_u_q[$];
  logic [AW-1:0] exp_s_q[$];
  int  eidx[2];
  bit  last_hs[2];
  int  done_cnt = 0;
  bit  first_pending = 0;
  int  first_ov_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_side(input int w, input logic ov, input logic rdy,
                            input logic [AW-1:0] d, input logic [3:0] ix,
                            input logic lst, input logic dn, input logic bz);
    string p;
    int qs;
    logic [AW-1:0] e;
    p  = (w == 0) ? "u" : "s";
    qs = (w == 0) ? exp_u_q.size() : exp_s_q.size();
    chk($sformatf("%s_done", p), 64'(dn), 64'(last_hs[w]));
    if (last_hs[w]) chk($sformatf("%s_busy_in_done", p), 64'(bz), 64'd0);
    last_hs[w] = 1'b0;
    if (ov) begin
      if (qs == 0) begin
        tests++;
        fails++;
        $display("FAIL %s_extra_beat: actual idx %0d data %0h required no beat", p, ix, d);
      end else begin
        e = (w == 0) ? exp_u_q[0] : exp_s_q[0];
        chk($sformatf("%s_data[%0d]", p, eidx[w]), 64'(d), 64'(e));
        chk($sformatf("%s_idx", p), 64'(ix), 64'(eidx[w]));
        chk($sformatf("%s_last", p), 64'(lst), 64'(eidx[w] == NN-1));
        if (rdy) begin
          if (w == 0) void'(exp_u_q.pop_front());
          else        void'(exp_s_q.pop_front());
          if (eidx[w] == NN-1) begin
            eidx[w]    = 0;
            last_hs[w] = 1'b1;
          end else begin
            eidx[w]++;
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (first_pending && u_out_valid) begin
        first_ov_cyc  = cyc;
        first_pending = 1'b0;
      end
      check_side(0, u_out_valid, out_ready, u_out_data, u_out_idx, u_out_last, u_done, u_busy);
      check_side(1, s_out_valid, out_ready, s_out_data, s_out_idx, s_out_last, s_done, s_busy);
      if (u_done) done_cnt++;
    end
  end

  // Consumer back-pressure: always ready, or ready roughly 60% of cycles.
  always @(posedge clk) begin
    #1;
    out_ready = (rdy_mode != 0) ? ($urandom_range(0, 99) >= 40) : 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_u_in_ready"},  64'(u_in_ready),  64'd0);
    chk({tag, "_u_out_valid"}, 64'(u_out_valid), 64'd0);
    chk({tag, "_u_out_data"},  64'(u_out_data),  64'd0);
    chk({tag, "_u_out_idx"},   64'(u_out_idx),   64'd0);
    chk({tag, "_u_out_last"},  64'(u_out_last),  64'd0);
    chk({tag, "_u_busy"},      64'(u_busy),      64'd0);
    chk({tag, "_u_done"},      64'(u_done),      64'd0);
    chk({tag, "_s_busy"},      64'(s_busy),      64'd0);
    chk({tag, "_s_out_valid"}, 64'(s_out_valid), 64'd0);
    chk({tag, "_s_in_ready"},  64'(s_in_ready),  64'd0);
  endtask

  // mode: 0 identity x (1..16), 1 A=FFFF B=2, 2 random (model), 3 K=0 zeros
  // vpat: 0 in_valid always 1, 1 repeating 1,0,0,1, 2 random
  task automatic run_job(input int k, input int mode, input int vpat, input bit poke);
    logic [N*DW-1:0] ac[$];
    logic [N*DW-1:0] br[$];
    logic [N*DW-1:0] av, bv;
    logic [AW-1:0]   eu[NN];
    logic [AW-1:0]   es[NN];
    logic [DW-1:0]   a, b;
    logic [63:0]     su, ss;
    bit              v, ok;
    int              got, c, lastc, d0;

    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < N; i++) begin
        case (mode)
          0:       begin av[i*DW +: DW] = (i == kk) ? 16'd1 : 16'd0;
                         bv[i*DW +: DW] = DW'(kk*N + i + 1); end
          1:       begin av[i*DW +: DW] = 16'hFFFF; bv[i*DW +: DW] = 16'h0002; end
          default: begin av[i*DW +: DW] = DW'($urandom_range(0, 65535));
                         bv[i*DW +: DW] = DW'($urandom_range(0, 65535)); end
        endcase
      end
      ac.push_back(av);
      br.push_back(bv);
    end

    for (int x = 0; x < NN; x++) begin
      case (mode)
        0:       begin eu[x] = AW'(x + 1);   es[x] = AW'(x + 1);   end
        1:       begin eu[x] = 32'h0005FFFA; es[x] = 32'hFFFFFFFA; end
        3:       begin eu[x] = '0;           es[x] = '0;           end
        default: begin
          su = '0;
          ss = '0;
          for (int kk = 0; kk < k; kk++) begin
            a  = ac[kk][(x / N)*DW +: DW];
            b  = br[kk][(x % N)*DW +: DW];
            su = su + ({48'd0, a} * {48'd0, b});
            ss = ss + (64'($signed(a)) * 64'($signed(b)));
          end
          eu[x] = su[AW-1:0];
          es[x] = ss[AW-1:0];
        end
      endcase
      exp_u_q.push_back(eu[x]);
      exp_s_q.push_back(es[x]);
    end

    first_pending = (k != 0);
    start = 1'b1;
    k_len = KW'(k);
    @(posedge clk);
    #1;
    start = 1'b0;
    k_len = KW'($urandom_range(0, 255));

    got   = 0;
    c     = 0;
    lastc = cyc;
    if (k != 0) begin
      while (got < k && c < 500) begin
        case (vpat)
          0:       v = 1'b1;
          1:       v = ((c % 4) == 0) || ((c % 4) == 3);
          default: v = 1'($urandom_range(0, 1));
        endcase
        in_valid = v;
        a_col    = v ? ac[got] : N*DW'({$urandom, $urandom});
        b_row    = v ? br[got] : N*DW'({$urandom, $urandom});
        @(negedge clk);
        chk("u_in_ready_load", 64'(u_in_ready), 64'd1);
        chk("s_in_ready_load", 64'(s_in_ready), 64'd1);
        chk("busy_load", 64'(u_busy), 64'd1);
        @(posedge clk);
        #1;
        if (v) got++;
        c++;
      end
      lastc = cyc;
      // Offer one more beat of garbage; the engine must refuse it.
      in_valid = 1'b1;
      a_col    = N*DW'({$urandom, $urandom});
      b_row    = N*DW'({$urandom, $urandom});
      @(negedge clk);
      chk("u_in_ready_after_k", 64'(u_in_ready), 64'd0);
      chk("s_in_ready_after_k", 64'(s_in_ready), 64'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end

    d0 = done_cnt;
    ok = 1'b0;
    for (int c2 = 0; c2 < 400; c2++) begin
      @(negedge clk);
      #1;
      if (poke && c2 == 5) begin start = 1'b1; k_len = 8'd3; end
      if (poke && c2 == 6) start = 1'b0;
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL job_timeout: actual no done within 400 cycles required done (mode %0d k %0d)", mode, k);
      exp_u_q.delete();
      exp_s_q.delete();
    end
    if (k != 0) chk("first_out_latency", 64'(first_ov_cyc - lastc), 64'(2*N));
    chk("u_beats_left", 64'(exp_u_q.size()), 64'd0);
    chk("s_beats_left", 64'(exp_s_q.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    eidx[0] = 0; eidx[1] = 0;
    last_hs[0] = 1'b0; last_hs[1] = 1'b0;

    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Identity x 1..16, full-rate input, always-ready output.
    run_job(4, 0, 0, 1'b0);
    // Same job with input bubbles (back-to-back start in the done cycle).
    run_job(4, 0, 1, 1'b0);
    // Same job with random back-pressure.
    rdy_mode = 1;
    run_job(4, 0, 0, 1'b0);
    rdy_mode = 0;
    // Signed / unsigned interpretation of FFFF * 2, K=3.
    run_job(3, 1, 0, 1'b0);
    // K=0 job with a stray start during drain, then a normal job.
    run_job(0, 3, 0, 1'b1);
    run_job(4, 0, 0, 1'b0);

    // Reset pulled mid-LOAD after two beats.
    start = 1'b1;
    k_len = 8'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) begin
      in_valid = 1'b1;
      a_col    = N*DW'({$urandom, $urandom});
      b_row    = N*DW'({$urandom, $urandom});
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run_job(4, 0, 0, 1'b0);

    // Random jobs against the matrix model.
    for (int r = 0; r < 8; r++) begin
      rdy_mode = r % 2;
      run_job($urandom_range(1, 12), 2, 2, 1'b0);
    end
    rdy_mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual simulation still running required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
